// File: rtl/snake_grid_builder_if.sv
// Body-cell stream between the grid builder (master) and the snake block (slave).
// The builder requests a traversal with shift; the snake answers with x/y/exists and end_shift.
interface snake_grid_builder_if #(
   parameter int unsigned H = 32,
   parameter int unsigned V = 32
) ();
   logic                 shift;
   logic [$clog2(H)-1:0] x;
   logic [$clog2(V)-1:0] y;
   logic                 exists;
   logic                 end_shift;

   modport master (
      output shift,
      input  x,
      input  y,
      input  exists,
      input  end_shift
   );

   modport slave (
      input  shift,
      output x,
      output y,
      output exists,
      output end_shift
   );
endinterface

// File: rtl/snake_grid_builder.sv
// Double-buffered occupancy grid: builds a back frame from the snake body stream on each tick,
// then swaps it to the front buffer that serves display-side point queries.
module snake_grid_builder #(
   parameter int unsigned H = 32,
   parameter int unsigned V = 32
) (
   input  logic                         i_clk,
   input  logic                         i_reset,
   input  logic                         i_tick,
   snake_grid_builder_if.master         io_snake,
   input  logic [$clog2(H)-1:0]         i_query_x,
   input  logic [$clog2(V)-1:0]         i_query_y,
   output logic                         o_query_hit,
   output logic                         o_busy,
   output logic                         o_frame_ready,
   output logic [$clog2(H*V):0]         o_cell_count,
   output logic                         o_overlap,
   output logic                         o_overrun,
   output logic                         o_timeout
);
   localparam int unsigned N  = H * V;
   localparam int unsigned CW = $clog2(N) + 1;
   localparam int unsigned WW = $clog2(N + 8);
   localparam logic [WW-1:0] WdogLast = WW'(N + 7);

   typedef enum logic [2:0] {StIdle, StClear, StReq, StCollect, StSwap} state_e;

   state_e          r_state, w_state_nxt;
   logic [N-1:0]    r_front, r_back;
   logic [CW-1:0]   r_front_count, r_back_count;
   logic            r_front_overlap, r_back_overlap;
   logic            r_pending, r_overrun, r_timeout, r_frame_ready, r_query_hit;
   logic [WW-1:0]   r_wdog;
   logic            w_start, w_wdog_expire, w_collect_wr, w_bit_old;
   logic [$clog2(N)-1:0] w_idx;

   // H is a power of two, so y*H+x is a plain concatenation.
   assign w_idx        = {io_snake.y, io_snake.x};
   assign w_bit_old    = r_back[w_idx];
   assign w_collect_wr = (r_state == StCollect) && io_snake.exists;

   always_comb begin
      w_state_nxt   = r_state;
      w_start       = 1'b0;
      w_wdog_expire = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (i_tick || r_pending) begin
               w_state_nxt = StClear;
               w_start     = 1'b1;
            end
         end
         StClear: w_state_nxt = StReq;
         StReq:   w_state_nxt = StCollect;
         StCollect: begin
            if (io_snake.end_shift) begin
               w_state_nxt = StSwap;
            end else if (r_wdog == WdogLast) begin
               w_state_nxt   = StIdle;
               w_wdog_expire = 1'b1;
            end
         end
         StSwap:  w_state_nxt = StIdle;
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state         <= StIdle;
         r_front         <= '0;
         r_back          <= '0;
         r_front_count   <= '0;
         r_back_count    <= '0;
         r_front_overlap <= 1'b0;
         r_back_overlap  <= 1'b0;
         r_pending       <= 1'b0;
         r_overrun       <= 1'b0;
         r_timeout       <= 1'b0;
         r_frame_ready   <= 1'b0;
         r_query_hit     <= 1'b0;
         r_wdog          <= '0;
      end else begin
         r_state <= w_state_nxt;

         // One request may wait behind the current build; any further one is lost.
         if (w_start) begin
            r_pending <= 1'b0;
         end else if (i_tick && (r_state != StIdle)) begin
            if (!r_pending) begin
               r_pending <= 1'b1;
            end else begin
               r_overrun <= 1'b1;
            end
         end

         r_wdog <= (r_state == StCollect) ? r_wdog + WW'(1) : '0;
         if (w_wdog_expire) begin
            r_timeout <= 1'b1;
         end

         if (r_state == StClear) begin
            r_back         <= '0;
            r_back_count   <= '0;
            r_back_overlap <= 1'b0;
         end

         if (w_collect_wr) begin
            r_back[w_idx] <= 1'b1;
            if (!w_bit_old) begin
               r_back_count <= r_back_count + CW'(1);
            end else begin
               r_back_overlap <= 1'b1;
            end
         end

         if (r_state == StSwap) begin
            r_front         <= r_back;
            r_front_count   <= r_back_count;
            r_front_overlap <= r_back_overlap;
         end

         r_frame_ready <= (r_state == StSwap);
         r_query_hit   <= r_front[{i_query_y, i_query_x}];
      end
   end

   assign io_snake.shift = (r_state == StReq) && !i_reset;
   assign o_busy         = (r_state != StIdle) && !i_reset;
   assign o_query_hit    = r_query_hit;
   assign o_frame_ready  = r_frame_ready;
   assign o_cell_count   = r_front_count;
   assign o_overlap      = r_front_overlap;
   assign o_overrun      = r_overrun;
   assign o_timeout      = r_timeout;
endmodule

// File: tb/tb_snake_grid_builder.sv
// Directed bench for snake_grid_builder (32x32): frame builds, overlap, pending/overrun,
// watchdog abort and mid-build reset, with expected frame results queued at stimulus time.
module tb_snake_grid_builder;
   localparam int unsigned H = 32;
   localparam int unsigned V = 32;

   logic        clk = 1'b0;
   logic        reset;
   logic        tick;
   logic [4:0]  qx, qy;
   logic        query_hit, busy, frame_ready, overlap, overrun, timeout;
   logic [10:0] cell_count;

   always #5 clk = ~clk;

   snake_grid_builder_if #(.H(H), .V(V)) sb ();

   snake_grid_builder #(.H(H), .V(V)) dut (
      .i_clk         (clk),
      .i_reset       (reset),
      .i_tick        (tick),
      .io_snake      (sb),
      .i_query_x     (qx),
      .i_query_y     (qy),
      .o_query_hit   (query_hit),
      .o_busy        (busy),
      .o_frame_ready (frame_ready),
      .o_cell_count  (cell_count),
      .o_overlap     (overlap),
      .o_overrun     (overrun),
      .o_timeout     (timeout)
   );

   int unsigned checks = 0;
   int unsigned errors = 0;
   int          cx[$];
   int          cy[$];
   int unsigned exp_cnt_q[$];
   bit          exp_ovl_q[$];
   bit [1023:0] exp_map_q[$];
   bit          q_exp_q[$];
   bit [1023:0] model_front;
   int unsigned model_count;
   bit          model_ovl;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic query(input int x, input int y);
      qx = 5'(x);
      qy = 5'(y);
      q_exp_q.push_back(model_front[y*H + x]);
      step();
      check($sformatf("query_%0d_%0d", x, y), 32'(query_hit), 32'(q_exp_q.pop_front()));
   endtask

   // Streams cx/cy as one frame; pend=1 means the build already sits in CLEAR.
   task automatic do_build(input bit pend, input int extra_ticks, input int hx, input int hy);
      bit [1023:0] m;
      int unsigned cnt;
      bit          ov;
      int          idx;
      bit          old_hit;
      m = '0; cnt = 0; ov = 1'b0;
      foreach (cx[i]) begin
         idx = cy[i]*H + cx[i];
         if (m[idx]) ov = 1'b1;
         else cnt++;
         m[idx] = 1'b1;
      end
      exp_cnt_q.push_back(cnt);
      exp_ovl_q.push_back(ov);
      exp_map_q.push_back(m);
      qx = 5'(hx);
      qy = 5'(hy);
      if (!pend) begin
         tick = 1'b1;
         step();
         tick = 1'b0;
         check("shift_t1", 32'(sb.shift), 32'(0));
         check("busy_t1", 32'(busy), 32'(1));
      end
      step();
      check("shift_t2", 32'(sb.shift), 32'(1));
      step();
      check("shift_single", 32'(sb.shift), 32'(0));
      for (int i = 0; i < cx.size(); i++) begin
         sb.exists    = 1'b1;
         sb.x         = 5'(cx[i]);
         sb.y         = 5'(cy[i]);
         sb.end_shift = (i == cx.size() - 1);
         tick         = (i < extra_ticks);
         step();
      end
      sb.exists = 1'b0; sb.end_shift = 1'b0; tick = 1'b0;
      old_hit = model_front[hy*H + hx];
      check("frame_ready_swap", 32'(frame_ready), 32'(0));
      step();
      check("frame_ready_pulse", 32'(frame_ready), 32'(1));
      check("hold_query_swap", 32'(query_hit), 32'(old_hit));
      model_count = exp_cnt_q.pop_front();
      model_ovl   = exp_ovl_q.pop_front();
      model_front = exp_map_q.pop_front();
      check("cell_count", 32'(cell_count), 32'(model_count));
      check("overlap", 32'(overlap), 32'(model_ovl));
      step();
      check("hold_query_next", 32'(query_hit), 32'(model_front[hy*H + hx]));
      check("frame_ready_single", 32'(frame_ready), 32'(0));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, 32'(busy), 32'(0));
      check({tag, "_shift"}, 32'(sb.shift), 32'(0));
      check({tag, "_frame_ready"}, 32'(frame_ready), 32'(0));
      check({tag, "_query_hit"}, 32'(query_hit), 32'(0));
      check({tag, "_overlap"}, 32'(overlap), 32'(0));
      check({tag, "_overrun"}, 32'(overrun), 32'(0));
      check({tag, "_timeout"}, 32'(timeout), 32'(0));
      check({tag, "_cell_count"}, 32'(cell_count), 32'(0));
   endtask

   initial begin
      int n;
      bit seen_fr;
      reset = 1'b1; tick = 1'b0; qx = '0; qy = '0;
      sb.x = '0; sb.y = '0; sb.exists = 1'b0; sb.end_shift = 1'b0;
      model_front = '0; model_count = 0; model_ovl = 1'b0;
      repeat (3) step();
      check_all_zero("reset");
      reset = 1'b0;
      step();
      check("post_reset_shift", 32'(sb.shift), 32'(0));

      // Basic frame with queries.
      cx = '{16, 15, 14}; cy = '{16, 16, 16};
      do_build(1'b0, 0, 0, 0);
      query(15, 16);
      query(15, 17);
      query(16, 16);
      query(13, 16);

      // Revisited cell: two distinct cells, overlap flagged.
      cx = '{3, 4, 3}; cy = '{3, 3, 3};
      do_build(1'b0, 0, 16, 16);
      query(3, 3);
      query(16, 16);

      // Three ticks during a build: one pending build follows, the rest are dropped.
      cx = '{16, 20, 21}; cy = '{16, 5, 5};
      check("overrun_before", 32'(overrun), 32'(0));
      do_build(1'b0, 3, 16, 16);
      check("overrun_set", 32'(overrun), 32'(1));
      check("pending_build_started", 32'(busy), 32'(1));
      cx = '{7}; cy = '{9};
      do_build(1'b1, 0, 16, 16);
      n = 0;
      repeat (6) begin
         step();
         if (busy !== 1'b0) n++;
      end
      check("no_third_build", 32'(n), 32'(0));

      // Watchdog: no end_shift ever arrives.
      check("timeout_before", 32'(timeout), 32'(0));
      tick = 1'b1; step(); tick = 1'b0;
      step();
      check("wd_shift", 32'(sb.shift), 32'(1));
      step();
      n = 0; seen_fr = 1'b0;
      while (busy === 1'b1 && n < 1100) begin
         step();
         n++;
         if (frame_ready) seen_fr = 1'b1;
      end
      check("wd_collect_cycles", 32'(n), 32'(1032));
      check("wd_timeout", 32'(timeout), 32'(1));
      check("wd_no_frame_ready", 32'(seen_fr), 32'(0));
      check("wd_count_kept", 32'(cell_count), 32'(model_count));
      check("wd_overlap_kept", 32'(overlap), 32'(model_ovl));
      query(7, 9);
      query(16, 16);

      // Reset in the 5th COLLECT cycle.
      qx = 5'd7; qy = 5'd9;
      tick = 1'b1; step(); tick = 1'b0;
      step(); step();
      for (int i = 0; i < 4; i++) begin
         sb.exists = 1'b1; sb.x = 5'(i); sb.y = 5'd1;
         step();
      end
      reset = 1'b1;
      step();
      sb.exists = 1'b0;
      check_all_zero("mid_reset");
      reset = 1'b0;
      model_front = '0;
      step();
      check("deassert_shift", 32'(sb.shift), 32'(0));
      check("deassert_busy", 32'(busy), 32'(0));
      query(7, 9);
      query(0, 1);
      query(16, 16);
      query(31, 31);
      check("scoreboard_drained", 32'(exp_cnt_q.size()), 32'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
